// File: rtl/mem_load_unit_if.sv
// Bundle of the request, response and data-memory signals of the load unit.
// The slave modport is the load unit. The master modport is its environment: the MEM stage plus the memory.
interface mem_load_unit_if;
  logic        re;
  logic [63:0] addr;
  logic [2:0]  func3;
  logic [4:0]  rd_in;
  logic [63:0] mem_rdata;
  logic        mem_re;
  logic [7:0]  mem_addr;
  logic [63:0] load_data;
  logic [4:0]  rd_out;
  logic        load_valid;
  logic        load_fault;
  logic        busy;

  modport master (
    output re, addr, func3, rd_in, mem_rdata,
    input  mem_re, mem_addr, load_data, rd_out, load_valid, load_fault, busy
  );

  modport slave (
    input  re, addr, func3, rd_in, mem_rdata,
    output mem_re, mem_addr, load_data, rd_out, load_valid, load_fault, busy
  );
endinterface

// File: rtl/mem_load_unit.sv
// Load path of the data-memory interface: issues one read per accepted request,
// waits MEM_LAT cycles, then returns the sign/zero-extended word with its register tag.
module mem_load_unit #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_load_unit_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int unsigned             CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0]        CNT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0]        CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]        CNT_ZERO = CNT_W'(0);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             accept_s;
  logic             capture_s;
  logic [2:0]       func3_r;
  logic [4:0]       rd_lat_r;
  logic [64:0]      ext_s;

  logic             mem_re_r;
  logic [7:0]       mem_addr_r;
  logic             busy_r;
  logic             load_valid_r;
  logic [63:0]      load_data_r;
  logic [4:0]       rd_out_r;
  logic             load_fault_r;

  // Bit 64 flags an illegal load type; the data field is then forced to zero.
  function automatic logic [64:0] extend_load(input logic [63:0] w, input logic [2:0] f3);
    logic [64:0] r;
    case (f3)
      3'b000:  r = {1'b0, {56{w[7]}},  w[7:0]};
      3'b001:  r = {1'b0, {48{w[15]}}, w[15:0]};
      3'b010:  r = {1'b0, {32{w[31]}}, w[31:0]};
      3'b011:  r = {1'b0, w};
      3'b100:  r = {1'b0, 56'h0, w[7:0]};
      3'b101:  r = {1'b0, 48'h0, w[15:0]};
      3'b110:  r = {1'b0, 32'h0, w[31:0]};
      default: r = {1'b1, 64'h0};
    endcase
    return r;
  endfunction

  // Next-state, latency counter and accept/capture strobes.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_RESP: begin
        if (bus.re) begin
          state_nxt_s = ST_ISSUE;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_nxt_s = ST_WAIT;
        cnt_nxt_s   = CNT_INIT;
      end
      ST_WAIT: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
          capture_s   = 1'b1;
          state_nxt_s = ST_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Extension of the memory word with the func3 latched at acceptance.
  always_comb begin
    ext_s = extend_load(bus.mem_rdata, func3_r);
  end

  // FSM state and counter; the strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      mem_re_r     <= 1'b0;
      busy_r       <= 1'b0;
      load_valid_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      mem_re_r     <= (state_nxt_s == ST_ISSUE);
      busy_r       <= (state_nxt_s == ST_ISSUE) || (state_nxt_s == ST_WAIT);
      load_valid_r <= (state_nxt_s == ST_RESP);
    end
  end

  // Request fields are latched on acceptance, so later changes upstream cannot leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_r <= 8'h00;
      func3_r    <= 3'b000;
      rd_lat_r   <= 5'd0;
    end else if (accept_s) begin
      mem_addr_r <= bus.addr[7:0];
      func3_r    <= bus.func3;
      rd_lat_r   <= bus.rd_in;
    end else begin
      mem_addr_r <= mem_addr_r;
      func3_r    <= func3_r;
      rd_lat_r   <= rd_lat_r;
    end
  end

  // Result registers hold until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_data_r  <= 64'h0;
      rd_out_r     <= 5'd0;
      load_fault_r <= 1'b0;
    end else if (capture_s) begin
      load_data_r  <= ext_s[63:0];
      rd_out_r     <= rd_lat_r;
      load_fault_r <= ext_s[64];
    end else begin
      load_data_r  <= load_data_r;
      rd_out_r     <= rd_out_r;
      load_fault_r <= load_fault_r;
    end
  end

  assign bus.mem_re     = mem_re_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.busy       = busy_r;
  assign bus.load_valid = load_valid_r;
  assign bus.load_data  = load_data_r;
  assign bus.rd_out     = rd_out_r;
  assign bus.load_fault = load_fault_r;

endmodule

// File: tb/tb_mem_load_unit.sv
// Bench for mem_load_unit: MEM_LAT=1 and MEM_LAT=3 instances share one stimulus stream.
// The streams are a vector table, hand sequences and a random phase, checked against an edge-count reference model.
module tb_mem_load_unit;

  localparam logic [63:0] POISON = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re;
  logic [63:0] addr;
  logic [2:0]  func3;
  logic [4:0]  rd_in;
  logic [63:0] mem [256];
  int          errors = 0;
  int          checks = 0;

  logic [1:0]  lv;
  logic [1:0]  mre;
  logic [1:0]  bsy;
  logic [1:0]  flt_o;
  logic [63:0] ld_o [2];
  logic [4:0]  rd_o [2];
  logic [7:0]  ma_o [2];

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The field width is 8 << func3[1:0] bits. Bit 2 of func3 selects zero-extension.
  function automatic logic [63:0] ref_ext(input logic [63:0] w, input logic [2:0] f);
    int          nb;
    logic [63:0] mask;
    logic [63:0] v;
    if (f == 3'b111) return 64'h0;
    nb = 8 << f[1:0];
    if (nb == 64) return w;
    mask = (64'd1 << nb) - 64'd1;
    v = w & mask;
    if (!f[2] && w[nb-1]) v = v | ~mask;
    return v;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lu
    localparam int L = (g == 0) ? 1 : 3;
    mem_load_unit_if bus ();
    logic [63:0] pipe [L];

    assign bus.re        = re;
    assign bus.addr      = addr;
    assign bus.func3     = func3;
    assign bus.rd_in     = rd_in;
    assign bus.mem_rdata = pipe[L-1];
    assign lv[g]    = bus.load_valid;
    assign mre[g]   = bus.mem_re;
    assign bsy[g]   = bus.busy;
    assign flt_o[g] = bus.load_fault;
    assign ld_o[g]  = bus.load_data;
    assign rd_o[g]  = bus.rd_out;
    assign ma_o[g]  = bus.mem_addr;

    mem_load_unit #(.MEM_LAT(L)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // The memory returns the word exactly L edges after sampling mem_re. Otherwise it returns poison.
    always @(posedge clk) begin
      pipe[0] <= bus.mem_re ? mem[bus.mem_addr] : POISON;
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end

    // Reference model, in edge numbers. Accept at edge a when idle. Busy lasts for edges a..a+L. The result is valid after edge a+1+L.
    initial begin : model
      int          k;
      int          acc;
      bit          accv;
      bit          pend;
      logic [63:0] pdata, hdata;
      logic [4:0]  prd, hrd;
      logic        pflt, hflt;
      logic [7:0]  haddr;
      k = 0; acc = 0; accv = 0; pend = 0;
      hdata = 64'h0; hrd = 5'd0; hflt = 1'b0; haddr = 8'h00;
      pdata = 64'h0; prd = 5'd0; pflt = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          k = 0; accv = 0; pend = 0;
          hdata = 64'h0; hrd = 5'd0; hflt = 1'b0; haddr = 8'h00;
        end else begin
          k++;
          if (pend && k == acc + 1 + L) begin
            hdata = pdata; hrd = prd; hflt = pflt; pend = 0;
          end
          if (re && (!accv || k >= acc + L + 2)) begin
            acc = k; accv = 1; pend = 1;
            haddr = addr[7:0];
            pdata = ref_ext(mem[addr[7:0]], func3);
            prd   = rd_in;
            pflt  = (func3 == 3'b111);
          end
        end
        chk($sformatf("L%0d mem_re k=%0d", L, k), mre[g], (rst_n && accv && k == acc));
        if (rst_n && accv && k == acc)
          chk($sformatf("L%0d mem_addr k=%0d", L, k), ma_o[g], haddr);
        chk($sformatf("L%0d busy k=%0d", L, k), bsy[g], (rst_n && accv && k >= acc && k <= acc + L));
        chk($sformatf("L%0d load_valid k=%0d", L, k), lv[g], (rst_n && accv && k == acc + 1 + L));
        chk($sformatf("L%0d load_data k=%0d", L, k), ld_o[g], hdata);
        chk($sformatf("L%0d rd_out k=%0d", L, k), rd_o[g], hrd);
        chk($sformatf("L%0d load_fault k=%0d", L, k), flt_o[g], hflt);
      end
    end
  end

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] w;
    logic [4:0]  rd;
    logic [63:0] exp;
    logic        flt;
  } vec_t;

  vec_t        tv [9];
  int          cnt [2];
  int          first [2];
  int          mcnt [2];
  logic [4:0]  rds [2][4];
  logic [63:0] dat [2][4];
  int          vc;

  initial begin
    rst_n = 1'b0; re = 1'b0; addr = 64'h0; func3 = 3'b000; rd_in = 5'd0;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};

    tv[0] = '{3'b000, 64'hABCD_0000_0000_0010, 64'h0000_0000_0000_0080, 5'd5,  64'hFFFF_FFFF_FFFF_FF80, 1'b0};
    tv[1] = '{3'b100, 64'h0000_0000_0000_0010, 64'h0000_0000_0000_0080, 5'd6,  64'h0000_0000_0000_0080, 1'b0};
    tv[2] = '{3'b001, 64'h0000_0000_0000_0020, 64'h1122_3344_8000_ABCD, 5'd7,  64'hFFFF_FFFF_FFFF_ABCD, 1'b0};
    tv[3] = '{3'b010, 64'h0000_0000_0000_0020, 64'h1122_3344_8000_ABCD, 5'd8,  64'hFFFF_FFFF_8000_ABCD, 1'b0};
    tv[4] = '{3'b110, 64'h0000_0000_0000_0020, 64'h1122_3344_8000_ABCD, 5'd10, 64'h0000_0000_8000_ABCD, 1'b0};
    tv[5] = '{3'b011, 64'hFFFF_0000_0000_0020, 64'h1122_3344_8000_ABCD, 5'd13, 64'h1122_3344_8000_ABCD, 1'b0};
    tv[6] = '{3'b101, 64'h0000_0000_0000_0021, 64'h5555_5555_7FFF_F00D, 5'd14, 64'h0000_0000_0000_F00D, 1'b0};
    tv[7] = '{3'b111, 64'h0000_0000_0000_0022, 64'h0000_0000_0000_017F, 5'd15, 64'h0000_0000_0000_0000, 1'b1};
    tv[8] = '{3'b000, 64'h0000_0000_0000_0022, 64'h0000_0000_0000_017F, 5'd31, 64'h0000_0000_0000_007F, 1'b0};

    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("reset mem_re", mre[g], 1'b0);   chk("reset mem_addr", ma_o[g], 8'h00);
      chk("reset load_data", ld_o[g], 64'h0); chk("reset rd_out", rd_o[g], 5'd0);
      chk("reset load_valid", lv[g], 1'b0); chk("reset load_fault", flt_o[g], 1'b0);
      chk("reset busy", bsy[g], 1'b0);
    end
    #1 rst_n = 1'b1;

    // Vector table. The request fields are scrambled right after acceptance.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk); #1;
      mem[tv[i].a[7:0]] = tv[i].w;
      re = 1'b1; addr = tv[i].a; func3 = tv[i].f3; rd_in = tv[i].rd;
      @(negedge clk); #1;
      re = 1'b0; addr = ~addr; func3 = 3'b011; rd_in = ~rd_in;
      repeat (6) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        chk($sformatf("vec%0d g%0d load_data", i, g), ld_o[g], tv[i].exp);
        chk($sformatf("vec%0d g%0d rd_out", i, g), rd_o[g], tv[i].rd);
        chk($sformatf("vec%0d g%0d load_fault", i, g), flt_o[g], tv[i].flt);
      end
    end

    // Latency and single pulse. re is pulsed again while both units are busy.
    @(negedge clk); #1;
    re = 1'b1; addr = 64'h40; func3 = 3'b010; rd_in = 5'd3;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin first[g] = -1; cnt[g] = 0; mcnt[g] = int'(mre[g]); end
    #1 re = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (lv[g] && first[g] < 0) first[g] = n;
        cnt[g] += int'(lv[g]);
        mcnt[g] += int'(mre[g]);
      end
      #1 re = (n == 1);
    end
    chk("latency L1", 64'(first[0]), 64'd2);
    chk("latency L3", 64'(first[1]), 64'd4);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("pulse count g%0d", g), 64'(cnt[g]), 64'd1);
      chk($sformatf("mem_re count g%0d", g), 64'(mcnt[g]), 64'd1);
    end

    // Back-to-back. re stays high and the second request changes the tag, address and type.
    mem[8'h30] = 64'h8877_6655_4433_2211;
    mem[8'h31] = 64'h0000_0001_F234_5678;
    @(negedge clk); #1;
    re = 1'b1; addr = 64'h30; func3 = 3'b011; rd_in = 5'd11;
    @(negedge clk); #1;
    addr = 64'h31; func3 = 3'b010; rd_in = 5'd12;
    for (int g = 0; g < 2; g++) cnt[g] = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (lv[g]) begin
          if (cnt[g] < 4) begin rds[g][cnt[g]] = rd_o[g]; dat[g][cnt[g]] = ld_o[g]; end
          cnt[g]++;
        end
      end
      #1 if (n == 5) re = 1'b0;
    end
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("b2b pulses g%0d", g), 64'(cnt[g]), 64'd2);
      if (cnt[g] >= 2) begin
        chk($sformatf("b2b rd0 g%0d", g), rds[g][0], 5'd11);
        chk($sformatf("b2b rd1 g%0d", g), rds[g][1], 5'd12);
        chk($sformatf("b2b data0 g%0d", g), dat[g][0], 64'h8877_6655_4433_2211);
        chk($sformatf("b2b data1 g%0d", g), dat[g][1], 64'hFFFF_FFFF_F234_5678);
      end
    end

    // Reset asserted while both units are waiting on memory.
    mem[8'h50] = 64'h0123_4567_89AB_CDEF;
    @(negedge clk); #1;
    re = 1'b1; addr = 64'h50; func3 = 3'b011; rd_in = 5'd9;
    @(negedge clk); #1 re = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("midrst mem_re", mre[g], 1'b0);     chk("midrst mem_addr", ma_o[g], 8'h00);
      chk("midrst load_data", ld_o[g], 64'h0); chk("midrst rd_out", rd_o[g], 5'd0);
      chk("midrst load_valid", lv[g], 1'b0);  chk("midrst load_fault", flt_o[g], 1'b0);
      chk("midrst busy", bsy[g], 1'b0);
    end
    @(negedge clk); #1 rst_n = 1'b1;
    vc = 0;
    repeat (6) begin @(negedge clk); vc += int'(lv[0]) + int'(lv[1]); end
    chk("no valid after reset", 64'(vc), 64'd0);
    #1;
    re = 1'b1; addr = 64'h50; func3 = 3'b011; rd_in = 5'd9;
    @(negedge clk); #1 re = 1'b0;
    repeat (6) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("post-reset data g%0d", g), ld_o[g], 64'h0123_4567_89AB_CDEF);
      chk($sformatf("post-reset rd g%0d", g), rd_o[g], 5'd9);
    end

    // Random phase. Only the reference model checks it.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); #1;
      re    = ($urandom_range(0, 2) != 0);
      addr  = {$urandom, $urandom};
      func3 = 3'($urandom_range(0, 7));
      rd_in = 5'($urandom_range(0, 31));
    end
    @(negedge clk); #1 re = 1'b0;
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
